// File: rtl/nv_nvdla_glb_csb_fwd.sv
// CSB request forwarder: passes one upstream request at a time to the GEC port and
// returns its response upstream, substituting an error response if none arrives in time.
module nv_nvdla_glb_csb_fwd #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2glb_req_pvld,
    output logic        csb2glb_req_prdy,
    input  logic [62:0] csb2glb_req_pd,
    output logic        glb2csb_resp_valid,
    output logic [33:0] glb2csb_resp_pd,
    output logic        csb2gec_req_pvld,
    input  logic        csb2gec_req_prdy,
    output logic [62:0] csb2gec_req_pd,
    input  logic        gec2csb_resp_valid,
    input  logic [33:0] gec2csb_resp_pd,
    output logic        stray_resp
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [62:0] req_q, req_d;
    logic        pvld_q, pvld_d;
    logic        resp_valid_q, resp_valid_d;
    logic [33:0] resp_pd_q, resp_pd_d;
    logic        stray_q, stray_d;
    logic        expect_resp;

    // Reads and non-posted writes get a response; posted writes do not.
    assign expect_resp = ~req_q[54] | req_q[55];

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_pd_d    = resp_pd_q;
        unique case (state_q)
            StIdle: begin
                if (csb2glb_req_pvld) begin
                    req_d   = csb2glb_req_pd;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (csb2gec_req_prdy) begin
                    if (expect_resp) begin
                        state_d = StWait;
                        timer_d = 16'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWait: begin
                // A real response wins over a timeout landing in the same cycle.
                if (gec2csb_resp_valid) begin
                    resp_valid_d = 1'b1;
                    resp_pd_d    = gec2csb_resp_pd;
                    state_d      = StIdle;
                end else if (timer_q == TimeoutLast) begin
                    resp_valid_d = 1'b1;
                    resp_pd_d    = {req_q[54], 1'b1, 32'h0};
                    state_d      = StIdle;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        pvld_d  = (state_d == StSend);
        stray_d = gec2csb_resp_valid && (state_q != StWait);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= StIdle;
            timer_q      <= 16'd0;
            req_q        <= 63'd0;
            pvld_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_pd_q    <= 34'd0;
            stray_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            req_q        <= req_d;
            pvld_q       <= pvld_d;
            resp_valid_q <= resp_valid_d;
            resp_pd_q    <= resp_pd_d;
            stray_q      <= stray_d;
        end
    end

    assign csb2glb_req_prdy   = (state_q == StIdle);
    assign csb2gec_req_pvld   = pvld_q;
    assign csb2gec_req_pd     = req_q;
    assign glb2csb_resp_valid = resp_valid_q;
    assign glb2csb_resp_pd    = resp_pd_q;
    assign stray_resp         = stray_q;

endmodule

// File: doc/nv_nvdla_glb_csb_fwd.md
NV_NVDLA_GLB_CSB_FWD -- requirements
Module: NV_NVDLA_GLB_csb_fwd

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of WAIT cycles without a response before an error response is generated; legal range is 1..65535.
REQ-002 SHALL have port nvdla_core_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port nvdla_core_rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port csb2glb_req_pvld, input, 1 bit: upstream request valid.
REQ-005 SHALL have port csb2glb_req_prdy, output, 1 bit: upstream request ready.
REQ-006 SHALL have port csb2glb_req_pd, input, 63 bits: request packet with fields addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61].
REQ-007 SHALL have port glb2csb_resp_valid, output, 1 bit: upstream response strobe.
REQ-008 SHALL have port glb2csb_resp_pd, output, 34 bits: response packet with fields rdat[31:0], error[32], id[33] (0 = read, 1 = write).
REQ-009 SHALL have port csb2gec_req_pvld, output, 1 bit: downstream request valid.
REQ-010 SHALL have port csb2gec_req_prdy, input, 1 bit: downstream request ready.
REQ-011 SHALL have port csb2gec_req_pd, output, 63 bits: downstream request packet, same format as csb2glb_req_pd.
REQ-012 SHALL have port gec2csb_resp_valid, input, 1 bit: downstream response strobe.
REQ-013 SHALL have port gec2csb_resp_pd, input, 34 bits: downstream response packet.
REQ-014 SHALL have port stray_resp, output, 1 bit: one-cycle pulse when a downstream response arrives while none is expected.

Function
REQ-015 SHALL implement an FSM with states IDLE, SEND and WAIT, with at most one transaction outstanding.
REQ-016 SHALL drive csb2glb_req_prdy = 1 only in IDLE; this output is decoded from the state register only, with no input-to-output combinational path.
REQ-017 SHALL, in IDLE when csb2glb_req_pvld = 1, capture csb2glb_req_pd into req_reg and move to SEND.
REQ-018 SHALL, in SEND, drive csb2gec_req_pvld = 1 and csb2gec_req_pd = req_reg, holding both stable until csb2gec_req_prdy = 1.
REQ-019 SHALL treat a request as expecting a response when write = 0, or when write = 1 and nposted = 1.
REQ-020 SHALL, when the SEND handshake completes, move to WAIT and clear the timer if a response is expected; otherwise it returns to IDLE.
REQ-021 SHALL drive csb2gec_req_pvld = 0 in IDLE and WAIT.
REQ-022 SHALL keep csb2gec_req_pd = req_reg in all states, so it holds its last value outside SEND.
REQ-023 SHALL, in WAIT on gec2csb_resp_valid = 1, register glb2csb_resp_valid = 1 and glb2csb_resp_pd = gec2csb_resp_pd on the next edge, then move to IDLE.
REQ-024 SHALL increment a 16-bit timer each WAIT cycle without a response.
REQ-025 SHALL, when the timer equals TIMEOUT-1 with no response in that cycle, emit an error response and move to IDLE; the error response is rdat = 0, error = 1, id = req_reg write bit.
REQ-026 SHALL give priority to a real response arriving in the same cycle as the timeout: the real response is forwarded and no error response is emitted.
REQ-027 SHALL assert glb2csb_resp_valid for exactly one cycle per response; glb2csb_resp_pd holds its value until the next response.
REQ-028 SHALL drop any gec2csb_resp_valid received in IDLE or SEND and pulse stray_resp = 1 on the next cycle.
REQ-029 SHALL meet these latencies with csb2gec_req_prdy = 1:
- Accept at cycle T gives csb2gec_req_pvld = 1 at T+1.
- For a posted write, csb2glb_req_prdy = 1 again at T+2.
- A response arriving at cycle R gives glb2csb_resp_valid = 1 at R+1.
- Back-to-back accepts can occur only after IDLE is re-entered.
REQ-030 SHALL never permit the timer to wrap; it is cleared on every entry to WAIT.

Reset
REQ-031 SHALL, on nvdla_core_rstn = 0, set the state to IDLE and clear all of the following to 0: timer, req_reg, csb2gec_req_pvld, csb2gec_req_pd, glb2csb_resp_valid, glb2csb_resp_pd, stray_resp.
REQ-032 SHALL, on reset during SEND or WAIT, abort the transaction without generating a response; the first cycle after deassertion has csb2glb_req_prdy = 1.

Verification
REQ-033 SHALL cover a read: pd with addr 0x00010 and write = 0 accepted, then a downstream response 0x0_DEADBEEF two cycles later -> glb2csb_resp_pd = 0x0_DEADBEEF, valid for 1 cycle, FSM back in IDLE.
REQ-034 SHALL cover a posted write: write = 1, nposted = 0 with csb2gec_req_prdy = 1 -> csb2gec_req_pvld for 1 cycle, no upstream response, csb2glb_req_prdy = 1 two cycles after accept.
REQ-035 SHALL cover backpressure: csb2gec_req_prdy = 0 for 5 cycles -> csb2gec_req_pvld and pd stay stable and csb2glb_req_prdy stays 0 throughout.
REQ-036 SHALL cover timeout: TIMEOUT = 4, a non-posted write with no downstream response -> glb2csb_resp_pd = 0x3_00000000, valid exactly once, on the cycle after the 4th WAIT cycle.
REQ-037 SHALL cover response on the timeout cycle: response 0x1_00000000 in the 4th WAIT cycle -> that value is forwarded and no error response is emitted.
REQ-038 SHALL cover stray response and reset: gec2csb_resp_valid in IDLE gives a stray_resp pulse with no upstream response; reset asserted in WAIT gives no response and prdy = 1 after deassertion.
